rv32i_uart_tx: RTL and testbench

- Memory-mapped UART transmit peripheral on the rv32i_soc data-memory port, alongside the data RAM.
- Consumes the core's data-bus write stream (addr, data_in, wr_mask, wr_en) and returns read data through a one-cycle registered read port, like the data RAM.
- Buffers bytes in a small FIFO and serialises them as 8N1 frames on a single output line.
- Gives test programs a console output path instead of relying only on register and memory dumps.

---
 rtl/rv32i_uart_pkg.sv | 24 ++
 rtl/rv32i_sync_fifo.sv | 54 +++++
 rtl/rv32i_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_rv32i_uart_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_uart_pkg.sv
// Shared constants for the rv32i UART transmit peripheral: register map,
// STATUS bit positions, serialiser state encoding and divisor floor.
package rv32i_uart_pkg;

   localparam logic [1:0] REG_TXDATA = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_BAUD   = 2'd2;

   localparam int unsigned STAT_BUSY  = 0;
   localparam int unsigned STAT_FULL  = 1;
   localparam int unsigned STAT_EMPTY = 2;
   localparam int unsigned STAT_OVF   = 3;

   localparam int unsigned DIV_W   = 16;
   localparam logic [15:0] DIV_MIN = 16'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Synchronous FIFO with a combinational head; push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module rv32i_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/rv32i_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register decode, TX FIFO, baud
// divisor and a START/DATA/STOP serialiser driving uart_tx.
module rv32i_uart_tx
   import rv32i_uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h0000_2000,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd434
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   input  logic [3:0]  wr_mask,
   input  logic        wr_en,
   input  logic        rd_en,
   output logic [31:0] data_out,
   output logic        uart_tx,
   output logic        irq_empty
);

   tx_state_t        state, state_n;
   logic [DIV_W-1:0] divisor;
   logic [DIV_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_cnt, bit_n;
   logic [7:0]       shift, shift_n;
   logic             overflow;
   logic             tx_n;

   logic             sel;
   logic [1:0]       off;
   logic             wr_tx_c, wr_stat_c, wr_baud_c;
   logic             push_c, pop_c;
   logic             busy;
   logic [7:0]       fifo_dout;
   logic             fifo_full, fifo_empty;
   logic [31:0]      rd_val_c;
   logic             unused_bits;

   assign unused_bits = ^{addr[1:0], data_in[31:16], wr_mask[3:2]};

   assign sel       = (addr[31:4] == BASE_ADDR[31:4]);
   assign off       = addr[3:2];
   assign wr_tx_c   = wr_en & sel & (off == REG_TXDATA) & wr_mask[0];
   assign wr_stat_c = wr_en & sel & (off == REG_STATUS) & wr_mask[0] & data_in[STAT_OVF];
   assign wr_baud_c = wr_en & sel & (off == REG_BAUD) & (wr_mask[1:0] == 2'b11);
   assign push_c    = wr_tx_c & (~fifo_full | pop_c);
   assign busy      = (state != S_IDLE);

   rv32i_sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_c),
      .pop   (pop_c),
      .din   (data_in[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Read mux uses pre-write register values.
   always_comb begin
      rd_val_c = '0;
      if (sel) begin
         case (off)
            REG_STATUS: rd_val_c = {28'b0, overflow, fifo_empty, fifo_full, busy};
            REG_BAUD:   rd_val_c = {16'b0, divisor};
            default:    rd_val_c = '0;
         endcase
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      bit_n   = bit_cnt;
      shift_n = shift;
      pop_c   = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop_c   = 1'b1;
               shift_n = fifo_dout;
               cnt_n   = divisor - 16'd1;
               state_n = S_START;
            end
         end
         S_START: begin
            if (cnt == '0) begin
               bit_n   = 3'd0;
               cnt_n   = divisor - 16'd1;
               state_n = S_DATA;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         S_DATA: begin
            if (cnt == '0) begin
               shift_n = {1'b0, shift[7:1]};
               cnt_n   = divisor - 16'd1;
               if (bit_cnt == 3'd7) state_n = S_STOP;
               else                 bit_n   = bit_cnt + 3'd1;
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         S_STOP: begin
            if (cnt == '0) begin
               cnt_n = divisor - 16'd1;
               if (!fifo_empty) begin
                  pop_c   = 1'b1;
                  shift_n = fifo_dout;
                  state_n = S_START;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               cnt_n = cnt - 16'd1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Line level for the state being entered, so uart_tx is registered.
   always_comb begin
      tx_n = 1'b1;
      case (state_n)
         S_START: tx_n = 1'b0;
         S_DATA:  tx_n = shift_n[0];
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         uart_tx   <= 1'b1;
         irq_empty <= 1'b1;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_cnt   <= bit_n;
         shift     <= shift_n;
         uart_tx   <= tx_n;
         // Going idle implies the FIFO is empty now; only a push can refill it.
         irq_empty <= (state_n == S_IDLE) & ~push_c;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         divisor  <= DIV_RESET;
         overflow <= 1'b0;
         data_out <= '0;
      end else begin
         if (wr_baud_c)
            divisor <= (data_in[15:0] < DIV_MIN) ? DIV_MIN : data_in[15:0];
         if (wr_tx_c & fifo_full & ~pop_c) overflow <= 1'b1;
         else if (wr_stat_c)               overflow <= 1'b0;
         if (rd_en) data_out <= rd_val_c;
      end
   end

endmodule

// File: tb/tb_rv32i_uart_tx.sv
// Self-checking bench for rv32i_uart_tx: directed scenarios plus random
// register traffic, compared every cycle against a frame-level model.
module tb_rv32i_uart_tx;

   localparam logic [31:0] BASE  = 32'h0000_2000;
   localparam int          DEPTH = 8;
   localparam int          DIVR  = 434;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] addr;
   logic [31:0] data_in;
   logic [3:0]  wr_mask;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] data_out;
   logic        uart_tx;
   logic        irq_empty;

   int compared   = 0;
   int mismatched = 0;

   rv32i_uart_tx #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (DEPTH),
      .DIV_RESET  (16'(DIVR))
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .addr      (addr),
      .data_in   (data_in),
      .wr_mask   (wr_mask),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .data_out  (data_out),
      .uart_tx   (uart_tx),
      .irq_empty (irq_empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   byte unsigned mq[$];
   bit           m_active;
   int           m_t;
   logic [7:0]   m_byte;
   int           m_fdiv;
   int           m_div;
   bit           m_ovf;
   logic [31:0]  m_dout;
   bit           m_valid = 1'b0;
   int           m_accepted = 0;
   logic         m_tx;
   logic         m_irq;

   function automatic logic frame_level();
      int b;
      b = m_t / m_fdiv;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_byte[b-1];
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      logic       msel;
      logic [1:0] moff;
      bit         pop, fend, wtx;
      if (!rst_n) begin
         mq.delete();
         m_active = 1'b0;
         m_t      = 0;
         m_fdiv   = 2;
         m_div    = DIVR;
         m_ovf    = 1'b0;
         m_dout   = '0;
         m_valid  = 1'b1;
      end else begin
         msel = (addr[31:4] == BASE[31:4]);
         moff = addr[3:2];
         if (rd_en) begin
            m_dout = '0;
            if (msel && moff == 2'd1)
               m_dout = {28'b0, m_ovf, mq.size() == 0, mq.size() == DEPTH, m_active};
            if (msel && moff == 2'd2)
               m_dout = 32'(m_div);
         end
         fend = m_active && (m_t == 10 * m_fdiv - 1);
         pop  = (!m_active || fend) && (mq.size() > 0);
         wtx  = wr_en && msel && moff == 2'd0 && wr_mask[0];
         if (pop) begin
            m_byte   = mq.pop_front();
            m_active = 1'b1;
            m_t      = 0;
            m_fdiv   = m_div;
         end else if (fend) begin
            m_active = 1'b0;
         end else if (m_active) begin
            m_t++;
         end
         if (wtx) begin
            if (mq.size() < DEPTH) begin
               mq.push_back(data_in[7:0]);
               m_accepted++;
            end else begin
               m_ovf = 1'b1;
            end
         end
         if (wr_en && msel && moff == 2'd1 && wr_mask[0] && data_in[3]) m_ovf = 1'b0;
         if (wr_en && msel && moff == 2'd2 && wr_mask[1:0] == 2'b11)
            m_div = (data_in[15:0] < 16'd2) ? 2 : int'(data_in[15:0]);
      end
      m_tx  = m_active ? frame_level() : 1'b1;
      m_irq = !m_active && (mq.size() == 0);
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         check("uart_tx", 32'(uart_tx), 32'(m_tx));
         check("irq_empty", 32'(irq_empty), 32'(m_irq));
         check("data_out", data_out, m_dout);
      end
   end

   // ---------------- stimulus helpers ----------------
   logic samp [0:399];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      addr = a; data_in = d; wr_mask = m; wr_en = 1'b1;
      tick();
      wr_en = 1'b0; wr_mask = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a);
      addr = a; rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   task automatic wait_low(input string name, output int waited);
      waited = 0;
      while (uart_tx !== 1'b0 && waited < 2000) begin
         tick();
         waited++;
      end
      if (uart_tx !== 1'b0) begin
         compared++;
         mismatched++;
         $display("FAIL %s: start bit not seen within 2000 cycles", name);
      end
   endtask

   task automatic capture(input int n);
      for (int i = 0; i < n; i++) begin
         samp[i] = uart_tx;
         tick();
      end
   endtask

   function automatic logic [7:0] dec(input int base, input int d);
      logic [7:0] r;
      for (int b = 0; b < 8; b++) r[b] = samp[base + (b + 1) * d + d / 2];
      return r;
   endfunction

   initial begin
      int         w, trans, lows, acc0;
      logic [9:0] lv;

      rst_n = 1'b0; addr = '0; data_in = '0; wr_mask = '0; wr_en = 1'b0; rd_en = 1'b0;
      repeat (3) tick();
      check("reset_uart_tx", 32'(uart_tx), 32'h1);
      check("reset_irq_empty", 32'(irq_empty), 32'h1);
      check("reset_data_out", data_out, 32'h0);
      rst_n = 1'b1;
      tick();
      rd(BASE + 32'h4);
      check("reset_status", data_out, 32'h4);

      // Divisor 4, single 0x55 frame.
      wr(BASE + 32'h8, 32'd4, 4'b0011);
      wr(BASE + 32'h0, 32'h55, 4'b0001);
      wait_low("t1_start", w);
      check("t1_start_latency", 32'(w), 32'd1);
      capture(40);
      for (int k = 0; k < 10; k++) lv[k] = samp[4 * k + 1];
      check("t1_levels", 32'(lv), 32'h2AA);
      trans = 0;
      for (int i = 1; i < 40; i++) if (samp[i] != samp[i-1]) trans++;
      check("t1_transitions", 32'(trans), 32'd9);
      check("t1_irq_after_stop", 32'(irq_empty), 32'h1);

      // Divisor 2, two back-to-back frames.
      wr(BASE + 32'h8, 32'd2, 4'b0011);
      wr(BASE + 32'h0, 32'hA1, 4'b0001);
      wr(BASE + 32'h0, 32'h3C, 4'b0001);
      wait_low("t2_start", w);
      capture(40);
      check("t2_byte0", 32'(dec(0, 2)), 32'hA1);
      check("t2_byte1", 32'(dec(20, 2)), 32'h3C);
      check("t2_no_gap", 32'({samp[19], samp[20]}), 32'h2);
      tick();

      // Divisor 16, overflow of the 8-entry FIFO.
      wr(BASE + 32'h8, 32'd16, 4'b0011);
      acc0 = m_accepted;
      for (int i = 0; i < 10; i++) wr(BASE + 32'h0, 32'(i), 4'b0001);
      check("t3_model_accepted", 32'(m_accepted - acc0), 32'd9);
      rd(BASE + 32'h4);
      check("t3_status_ovf", data_out, 32'hB);
      wr(BASE + 32'h4, 32'h8, 4'b0001);
      rd(BASE + 32'h4);
      check("t3_status_clr", data_out, 32'h3);
      w = 0;
      while (irq_empty !== 1'b1 && w < 3000) begin tick(); w++; end
      check("t3_drained", 32'(irq_empty), 32'h1);

      // Divisor floor and unmapped reads.
      wr(BASE + 32'h8, 32'd0, 4'b0011);
      rd(BASE + 32'h8);
      check("t4_baud_min", data_out, 32'h2);
      rd(BASE + 32'hC);
      check("t4_reserved", data_out, 32'h0);
      rd(BASE + 32'h8);
      rd(32'h0000_1000);
      check("t4_unselected", data_out, 32'h0);

      // Reset during data bit 3 of an 0xFF frame at divisor 8.
      wr(BASE + 32'h8, 32'd8, 4'b0011);
      wr(BASE + 32'h0, 32'hFF, 4'b0001);
      wr(BASE + 32'h0, 32'h00, 4'b0001);
      wait_low("t5_start", w);
      repeat (34) tick();
      check("t5_irq_before", 32'(irq_empty), 32'h0);
      rst_n = 1'b0;
      tick();
      check("t5_tx_after_rst", 32'(uart_tx), 32'h1);
      check("t5_irq_after_rst", 32'(irq_empty), 32'h1);
      rst_n = 1'b1;
      rd(BASE + 32'h4);
      check("t5_status", data_out, 32'h4);
      rd(BASE + 32'h8);
      check("t5_baud", data_out, 32'd434);
      lows = 0;
      for (int i = 0; i < 200; i++) begin
         if (uart_tx !== 1'b1) lows++;
         tick();
      end
      check("t5_no_frame", 32'(lows), 32'h0);

      // Partial byte-lane writes are ignored.
      wr(BASE + 32'h0, 32'h77, 4'b0010);
      rd(BASE + 32'h4);
      check("t6_status", data_out, 32'h4);
      wr(BASE + 32'h8, 32'd5, 4'b0001);
      rd(BASE + 32'h8);
      check("t6_baud", data_out, 32'd434);

      // Random register traffic checked by the model each cycle.
      wr(BASE + 32'h8, 32'd3, 4'b0011);
      for (int n = 0; n < 2500; n++) begin
         int          r;
         logic [31:0] a;
         r = int'($urandom_range(0, 99));
         if (r < 35) begin
            a = ($urandom_range(0, 9) == 0) ? 32'h0000_3000 : BASE;
            a = a | 32'($urandom_range(0, 3));
            wr(a, $urandom, ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0001);
         end else if (r < 45) begin
            case ($urandom_range(0, 3))
               0:       rd(BASE + 32'h4);
               1:       rd(BASE + 32'h8);
               2:       rd(BASE + 32'hC);
               default: rd(32'h0000_1004);
            endcase
         end else if (r < 50) begin
            wr(BASE + 32'h4, 32'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         end else if (r < 53 && m_irq) begin
            wr(BASE + 32'h8, 32'($urandom_range(0, 6)),
               ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0011);
         end else begin
            tick();
         end
      end
      w = 0;
      while (!m_irq && w < 5000) begin tick(); w++; end
      check("final_drained", 32'(irq_empty), 32'h1);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
